// File: rtl/l2_port_arbiter.sv
// Purpose : merges NUM_CH L1 request channels onto the single L2 request port, one transaction at a time.
// Latency : ch_req sampled at edge 0, l2_req high after edge 0, ch_ack/ch_err no earlier than after edge 1; back in IDLE one edge later.
// Backpressure: a requester holds ch_req and its payload until it sees its ch_ack/ch_err pulse; l2_req stays high until l2_ack or the watchdog fires.
// Ports   : clk_l2/rst_n; ch_req/ch_write/ch_addr/ch_wdata in, ch_ack/ch_err/ch_rdata out (per channel);
//           l2_req/l2_write/l2_addr/l2_wdata out, l2_ack/l2_rdata in; busy and grant_id status out. All outputs registered.
module l2_port_arbiter #(
    parameter int NUM_CH   = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ARB_MODE = 0,
    parameter int TIMEOUT  = 16,
    parameter int GID_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk_l2,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_write,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
    output logic [NUM_CH-1:0]        ch_ack,
    output logic [NUM_CH-1:0]        ch_err,
    output logic [DATA_W-1:0]        ch_rdata,
    output logic                     l2_req,
    output logic                     l2_write,
    output logic [ADDR_W-1:0]        l2_addr,
    output logic [DATA_W-1:0]        l2_wdata,
    input  logic                     l2_ack,
    input  logic [DATA_W-1:0]        l2_rdata,
    output logic                     busy,
    output logic [GID_W-1:0]         grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RESP
    } state_t;

    localparam int               CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int               TMO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TMO_LAST_I);
    localparam logic [GID_W-1:0] LAST_RST   = GID_W'(NUM_CH - 1);

    state_t              state_q, state_d;
    logic                l2_req_q, l2_req_d;
    logic                l2_write_q, l2_write_d;
    logic [ADDR_W-1:0]   l2_addr_q, l2_addr_d;
    logic [DATA_W-1:0]   l2_wdata_q, l2_wdata_d;
    logic [NUM_CH-1:0]   ch_ack_q, ch_ack_d;
    logic [NUM_CH-1:0]   ch_err_q, ch_err_d;
    logic [DATA_W-1:0]   ch_rdata_q, ch_rdata_d;
    logic                busy_q, busy_d;
    logic [GID_W-1:0]    grant_id_q, grant_id_d;
    logic [GID_W-1:0]    last_grant_q, last_grant_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // Arbitration results
    logic                lo_vld, hi_vld, win_vld;
    logic [GID_W-1:0]    lo_id, hi_id, win_id;
    logic                sel_write;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [NUM_CH-1:0]   grant_oh;

    // Round-robin as two priority scans: the first requester above the last
    // grant wins; if there is none, the search wraps to the lowest requester.
    // Fixed priority is just the wrapped (lowest-index) scan.
    always_comb begin
        lo_vld = 1'b0;
        lo_id  = '0;
        hi_vld = 1'b0;
        hi_id  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!lo_vld && ch_req[i]) begin
                lo_vld = 1'b1;
                lo_id  = GID_W'(i);
            end
            if (!hi_vld && ch_req[i] && (i > int'(last_grant_q))) begin
                hi_vld = 1'b1;
                hi_id  = GID_W'(i);
            end
        end
        win_vld = lo_vld;
        win_id  = ((ARB_MODE == 0) && hi_vld) ? hi_id : lo_id;
    end

    // Payload of the winner, and one-hot of the held grant for the response pulses.
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        grant_oh  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(win_id) == i) begin
                sel_write = ch_write[i];
                sel_addr  = ch_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = ch_wdata[i*DATA_W +: DATA_W];
            end
            grant_oh[i] = (int'(grant_id_q) == i);
        end
    end

    always_comb begin
        state_d      = state_q;
        l2_req_d     = l2_req_q;
        l2_write_d   = l2_write_q;
        l2_addr_d    = l2_addr_q;
        l2_wdata_d   = l2_wdata_q;
        ch_ack_d     = '0;
        ch_err_d     = '0;
        ch_rdata_d   = ch_rdata_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    state_d      = ST_ISSUE;
                    l2_req_d     = 1'b1;
                    l2_write_d   = sel_write;
                    l2_addr_d    = sel_addr;
                    l2_wdata_d   = sel_wdata;
                    grant_id_d   = win_id;
                    last_grant_d = win_id;
                    cnt_d        = '0;
                end
            end
            ST_ISSUE: begin
                // An ack in the same cycle as the watchdog expiry takes precedence.
                if (l2_ack) begin
                    state_d    = ST_RESP;
                    l2_req_d   = 1'b0;
                    ch_ack_d   = grant_oh;
                    ch_rdata_d = l2_rdata;
                end else if (TIMEOUT != 0) begin
                    // cnt_q counts edges already spent waiting; this edge is number cnt_q+1.
                    if (cnt_q == TMO_LAST) begin
                        state_d  = ST_RESP;
                        l2_req_d = 1'b0;
                        ch_err_d = grant_oh;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_l2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            l2_req_q     <= 1'b0;
            l2_write_q   <= 1'b0;
            l2_addr_q    <= '0;
            l2_wdata_q   <= '0;
            ch_ack_q     <= '0;
            ch_err_q     <= '0;
            ch_rdata_q   <= '0;
            busy_q       <= 1'b0;
            grant_id_q   <= '0;
            last_grant_q <= LAST_RST;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            l2_req_q     <= l2_req_d;
            l2_write_q   <= l2_write_d;
            l2_addr_q    <= l2_addr_d;
            l2_wdata_q   <= l2_wdata_d;
            ch_ack_q     <= ch_ack_d;
            ch_err_q     <= ch_err_d;
            ch_rdata_q   <= ch_rdata_d;
            busy_q       <= busy_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    assign ch_ack   = ch_ack_q;
    assign ch_err   = ch_err_q;
    assign ch_rdata = ch_rdata_q;
    assign l2_req   = l2_req_q;
    assign l2_write = l2_write_q;
    assign l2_addr  = l2_addr_q;
    assign l2_wdata = l2_wdata_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Purpose : directed scoreboard bench for l2_port_arbiter (round-robin instance A, fixed-priority/short-timeout instance B).
// Latency : inputs driven and outputs sampled on the falling edge, half a cycle away from the active edge.
// Backpressure: the bench plays both the L1 requesters and the L2, holding requests until the response pulse.
module tb_l2_port_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NCH-1:0]  ch_req_a, ch_req_b, ch_write;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH*DW-1:0] ch_wdata;
    logic            l2_ack_a, l2_ack_b;
    logic [DW-1:0]   l2_rdata;

    logic [NCH-1:0]  ch_ack_a, ch_err_a, ch_ack_b, ch_err_b;
    logic [DW-1:0]   ch_rdata_a, ch_rdata_b;
    logic            l2_req_a, l2_write_a, busy_a, l2_req_b, l2_write_b, busy_b;
    logic [AW-1:0]   l2_addr_a, l2_addr_b;
    logic [DW-1:0]   l2_wdata_a, l2_wdata_b;
    logic [1:0]      grant_id_a, grant_id_b;

    always #5 clk = ~clk;

    l2_port_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0), .TIMEOUT(16)) u_rr (
        .clk_l2(clk), .rst_n(rst_n), .ch_req(ch_req_a), .ch_write(ch_write), .ch_addr(ch_addr),
        .ch_wdata(ch_wdata), .ch_ack(ch_ack_a), .ch_err(ch_err_a), .ch_rdata(ch_rdata_a),
        .l2_req(l2_req_a), .l2_write(l2_write_a), .l2_addr(l2_addr_a), .l2_wdata(l2_wdata_a),
        .l2_ack(l2_ack_a), .l2_rdata(l2_rdata), .busy(busy_a), .grant_id(grant_id_a)
    );

    l2_port_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1), .TIMEOUT(4)) u_fp (
        .clk_l2(clk), .rst_n(rst_n), .ch_req(ch_req_b), .ch_write(ch_write), .ch_addr(ch_addr),
        .ch_wdata(ch_wdata), .ch_ack(ch_ack_b), .ch_err(ch_err_b), .ch_rdata(ch_rdata_b),
        .l2_req(l2_req_b), .l2_write(l2_write_b), .l2_addr(l2_addr_b), .l2_wdata(l2_wdata_b),
        .l2_ack(l2_ack_b), .l2_rdata(l2_rdata), .busy(busy_b), .grant_id(grant_id_b)
    );

    typedef struct {
        bit          err;
        int          ch;
        logic [31:0] rdata;
    } cmp_t;

    typedef struct {
        int          ch;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } iss_t;

    cmp_t exp_a[$];
    cmp_t exp_b[$];
    iss_t iss_a[$];
    int   n_asserts = 0;
    int   n_fail    = 0;
    logic req_prev_a = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic cmp_t mk_cmp(input bit err, input int ch, input logic [31:0] rd);
        cmp_t c;
        c.err   = err;
        c.ch    = ch;
        c.rdata = rd;
        return c;
    endfunction

    function automatic iss_t mk_iss(input int ch, input logic wr, input logic [31:0] a, input logic [31:0] d);
        iss_t s;
        s.ch    = ch;
        s.wr    = wr;
        s.addr  = a;
        s.wdata = d;
        return s;
    endfunction

    // Response scoreboard, instance A
    always @(negedge clk) begin : mon_a
        cmp_t e;
        if (|ch_ack_a || |ch_err_a) begin
            if (exp_a.size() == 0) begin
                check("a_unexpected_resp", {ch_ack_a, ch_err_a}, 64'd0);
            end else begin
                e = exp_a.pop_front();
                check("a_ack", ch_ack_a, e.err ? 64'd0 : (64'd1 << e.ch));
                check("a_err", ch_err_a, e.err ? (64'd1 << e.ch) : 64'd0);
                check("a_rdata", ch_rdata_a, e.rdata);
            end
        end
    end

    // Response scoreboard, instance B
    always @(negedge clk) begin : mon_b
        cmp_t e;
        if (|ch_ack_b || |ch_err_b) begin
            if (exp_b.size() == 0) begin
                check("b_unexpected_resp", {ch_ack_b, ch_err_b}, 64'd0);
            end else begin
                e = exp_b.pop_front();
                check("b_ack", ch_ack_b, e.err ? 64'd0 : (64'd1 << e.ch));
                check("b_err", ch_err_b, e.err ? (64'd1 << e.ch) : 64'd0);
                check("b_rdata", ch_rdata_b, e.rdata);
            end
        end
    end

    // Issue scoreboard, instance A: compared on each rising l2_req
    always @(negedge clk) begin : mon_iss
        iss_t s;
        if (l2_req_a && !req_prev_a) begin
            if (iss_a.size() == 0) begin
                check("a_unexpected_issue", 64'(l2_req_a), 64'd0);
            end else begin
                s = iss_a.pop_front();
                check("iss_gid", grant_id_a, s.ch);
                check("iss_write", l2_write_a, s.wr);
                check("iss_addr", l2_addr_a, s.addr);
                check("iss_wdata", l2_wdata_a, s.wdata);
            end
        end
        req_prev_a = l2_req_a;
    end

    initial begin
        int rr_order[5];
        rr_order = '{0, 1, 2, 3, 0};
        ch_req_a = '0; ch_req_b = '0; ch_write = '0; ch_addr = '0; ch_wdata = '0;
        l2_ack_a = 1'b0; l2_ack_b = 1'b0; l2_rdata = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_a_ctl", {l2_req_a, l2_write_a, busy_a, grant_id_a, ch_ack_a, ch_err_a}, 64'd0);
        check("rst_a_addr", l2_addr_a, 64'd0);
        check("rst_a_wdata", l2_wdata_a, 64'd0);
        check("rst_a_rdata", ch_rdata_a, 64'd0);
        check("rst_b_ctl", {l2_req_b, l2_write_b, busy_b, grant_id_b, ch_ack_b, ch_err_b}, 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            ch_addr[i*AW +: AW]  = 32'h1000 + 32'(i) * 32'h100;
            ch_wdata[i*DW +: DW] = 32'hA000 + 32'(i);
        end

        // Round-robin fairness: all four request, L2 acks immediately
        l2_rdata = 32'h0000_0777;
        l2_ack_a = 1'b1;
        ch_req_a = 4'hF;
        for (int i = 0; i < 5; i++) begin
            iss_a.push_back(mk_iss(rr_order[i], 1'b0, 32'h1000 + 32'(rr_order[i]) * 32'h100, 32'hA000 + 32'(rr_order[i])));
            exp_a.push_back(mk_cmp(1'b0, rr_order[i], 32'h0000_0777));
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rr_req", l2_req_a, 64'd1);
            check("rr_gid", grant_id_a, rr_order[i]);
            @(negedge clk);
            if (i == 4) begin
                ch_req_a = '0;
                l2_ack_a = 1'b0;
            end
            @(negedge clk);
            check("rr_idle", {l2_req_a, busy_a}, 64'd0);
        end

        // Single read
        ch_addr[0 +: AW] = 32'h0004_0010;
        l2_rdata = 32'h0000_0567;
        iss_a.push_back(mk_iss(0, 1'b0, 32'h0004_0010, 32'hA000));
        exp_a.push_back(mk_cmp(1'b0, 0, 32'h0000_0567));
        check("rd_busy_pre", busy_a, 64'd0);
        ch_req_a = 4'b0001;
        @(negedge clk);
        check("rd_l2_req", l2_req_a, 64'd1);
        check("rd_l2_addr", l2_addr_a, 64'h0004_0010);
        check("rd_l2_write", l2_write_a, 64'd0);
        check("rd_busy1", busy_a, 64'd1);
        check("rd_no_ack_yet", ch_ack_a, 64'd0);
        l2_ack_a = 1'b1;
        @(negedge clk);
        check("rd_ack", ch_ack_a, 64'd1);
        check("rd_rdata", ch_rdata_a, 64'h567);
        check("rd_busy2", busy_a, 64'd1);
        check("rd_req_drop", l2_req_a, 64'd0);
        ch_req_a = '0;
        l2_ack_a = 1'b0;
        @(negedge clk);
        check("rd_busy_post", busy_a, 64'd0);
        check("rd_ack_one_pulse", ch_ack_a, 64'd0);

        // Write passthrough with a delayed ack
        ch_write = 4'b0010;
        ch_addr[AW +: AW]  = 32'h0000_0040;
        ch_wdata[DW +: DW] = 32'h0000_0567;
        l2_rdata = 32'h0000_1234;
        iss_a.push_back(mk_iss(1, 1'b1, 32'h0000_0040, 32'h0000_0567));
        exp_a.push_back(mk_cmp(1'b0, 1, 32'h0000_1234));
        ch_req_a = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("wr_req", l2_req_a, 64'd1);
            check("wr_write", l2_write_a, 64'd1);
            check("wr_wdata", l2_wdata_a, 64'h567);
            check("wr_no_ack", ch_ack_a, 64'd0);
            if (k == 5) l2_ack_a = 1'b1;
        end
        @(negedge clk);
        check("wr_ack_edge6", ch_ack_a, 64'b0010);
        ch_req_a = '0;
        l2_ack_a = 1'b0;
        ch_write = '0;
        @(negedge clk);
        check("wr_busy_post", busy_a, 64'd0);

        // Reset mid-ISSUE: ch0 and ch1 request, ch0 is granted (pointer at ch1)
        ch_addr[0 +: AW] = 32'h0000_2000;
        iss_a.push_back(mk_iss(0, 1'b0, 32'h0000_2000, 32'hA000));
        ch_req_a = 4'b0011;
        @(negedge clk);
        check("arst_pre_gid", grant_id_a, 64'd0);
        check("arst_pre_req", l2_req_a, 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_ctl", {l2_req_a, l2_write_a, busy_a, grant_id_a, ch_ack_a, ch_err_a}, 64'd0);
        check("arst_addr", l2_addr_a, 64'd0);
        check("arst_wdata", l2_wdata_a, 64'd0);
        check("arst_rdata", ch_rdata_a, 64'd0);
        @(negedge clk);
        @(negedge clk);
        check("arst_no_resp", {ch_ack_a, ch_err_a}, 64'd0);
        rst_n = 1'b1;
        l2_rdata = 32'h0000_5555;
        l2_ack_a = 1'b1;
        iss_a.push_back(mk_iss(0, 1'b0, 32'h0000_2000, 32'hA000));
        exp_a.push_back(mk_cmp(1'b0, 0, 32'h0000_5555));
        @(negedge clk);
        check("arst_regrant_gid", grant_id_a, 64'd0);
        check("arst_regrant_req", l2_req_a, 64'd1);
        @(negedge clk);
        ch_req_a = '0;
        l2_ack_a = 1'b0;
        @(negedge clk);

        // Fixed priority: ch1 and ch3 request, ch1 wins until it drops
        l2_rdata = 32'h1111_0001;
        l2_ack_b = 1'b1;
        ch_req_b = 4'b1010;
        for (int i = 0; i < 3; i++) exp_b.push_back(mk_cmp(1'b0, 1, 32'h1111_0001));
        exp_b.push_back(mk_cmp(1'b0, 3, 32'h1111_0001));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("fp_req", l2_req_b, 64'd1);
            check("fp_gid_ch1", grant_id_b, 64'd1);
            @(negedge clk);
            if (i == 2) ch_req_b = 4'b1000;
            @(negedge clk);
            check("fp_idle", l2_req_b, 64'd0);
        end
        @(negedge clk);
        check("fp_gid_ch3", grant_id_b, 64'd3);
        check("fp_req_ch3", l2_req_b, 64'd1);
        @(negedge clk);
        check("fp_ack_ch3", ch_ack_b, 64'b1000);
        ch_req_b = '0;
        l2_ack_b = 1'b0;
        @(negedge clk);

        // Timeout (TIMEOUT = 4): L2 never acks; ch_rdata keeps its old value
        l2_rdata = 32'h2222_0002;
        exp_b.push_back(mk_cmp(1'b1, 2, 32'h1111_0001));
        ch_req_b = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("to_req_high", l2_req_b, 64'd1);
            check("to_no_err", ch_err_b, 64'd0);
        end
        @(negedge clk);
        check("to_req_low", l2_req_b, 64'd0);
        check("to_err", ch_err_b, 64'b0100);
        check("to_no_ack", ch_ack_b, 64'd0);
        ch_req_b = '0;
        @(negedge clk);
        check("to_err_one_pulse", ch_err_b, 64'd0);
        check("to_busy_post", busy_b, 64'd0);

        // Ack in the expiry cycle wins over the timeout
        exp_b.push_back(mk_cmp(1'b0, 2, 32'h2222_0002));
        ch_req_b = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bnd_req_high", l2_req_b, 64'd1);
            if (k == 3) l2_ack_b = 1'b1;
        end
        @(negedge clk);
        check("bnd_ack", ch_ack_b, 64'b0100);
        check("bnd_no_err", ch_err_b, 64'd0);
        ch_req_b = '0;
        l2_ack_b = 1'b0;
        repeat (2) @(negedge clk);

        check("a_resp_queue_empty", exp_a.size(), 64'd0);
        check("b_resp_queue_empty", exp_b.size(), 64'd0);
        check("a_issue_queue_empty", iss_a.size(), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
